// File: rtl/flash_arb_pkg.sv
// Shared types for the SPI flash port arbiter: FSM states, requester
// indices and the operation encoding derived from we/tga.
package flash_arb_pkg;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_IDLE,
    ST_ISSUE,
    ST_BACKOFF,
    ST_DONE
  } state_e;

  localparam logic REQ_PATCH    = 1'b0;
  localparam logic REQ_SETTINGS = 1'b1;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_ERASE
  } op_e;

  // tga only has meaning when we is set; a read never carries the erase tag
  function automatic op_e op_decode(input logic we, input logic tga);
    if (!we) return OP_READ;
    return tga ? OP_ERASE : OP_WRITE;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-grant pointer moves only when the
// owner of the port strobes update_i.
module rr_arbiter2
  import flash_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       update_idx_i,
  output logic       grant_o,
  output logic       valid_o
);

  logic last_q;

  // Reset to the settings requester so the patch loader wins the first tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= REQ_SETTINGS;
    end else if (update_i) begin
      last_q <= update_idx_i;
    end
  end

  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      grant_o = ~last_q;
    end else if (req_i[REQ_SETTINGS]) begin
      grant_o = REQ_SETTINGS;
    end else begin
      grant_o = REQ_PATCH;
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Shares the single SPI flash slave port between the patch loader and the
// settings store, hiding flash-busy retries behind a timed back-off.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int BACKOFF_CYCLES = 1000,
  parameter int GAP_CYCLES     = 8,
  parameter int MAX_RETRY      = 50000,
  parameter int RETRY_W        = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0][23:0] s_adr_i,
  input  logic [1:0][31:0] s_dat_i,
  input  logic [1:0]      s_we_i,
  input  logic [1:0]      s_tga_i,
  input  logic [1:0]      s_stb_i,
  output logic [31:0]     s_dat_o,
  output logic [1:0]      s_ack_o,
  output logic [1:0]      s_err_o,
  output logic [23:0]     m_adr_o,
  output logic [31:0]     m_dat_o,
  output logic            m_we_o,
  output logic            m_tga_o,
  output logic            m_stb_o,
  input  logic [31:0]     m_dat_i,
  input  logic            m_ack_i,
  input  logic            m_rty_i
);

  localparam int BO_LEN = (BACKOFF_CYCLES > GAP_CYCLES) ? BACKOFF_CYCLES : GAP_CYCLES;
  localparam int CNT_W  = $clog2(BO_LEN + 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BO_LAST   = CNT_W'(BO_LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 grant_q;
  logic                 arb_grant;
  logic                 arb_valid;
  logic                 req_live;
  logic                 stb_ack;
  logic                 stb_rty;
  logic                 retry_last;
  logic                 ptr_upd;
  op_e                  grant_op;

  assign req_live   = s_stb_i[grant_q];
  assign stb_ack    = (state == ST_ISSUE) && m_stb_o && m_ack_i;
  assign stb_rty    = (state == ST_ISSUE) && m_stb_o && !m_ack_i && m_rty_i;
  assign retry_last = (retry_cnt + RETRY_W'(1)) == RETRY_MAX;
  assign grant_op   = op_decode(s_we_i[arb_grant], s_tga_i[arb_grant]);

  // The pointer moves whenever the granted request finishes, fails or is abandoned
  assign ptr_upd = stb_ack
                 || (stb_rty && (retry_last || !req_live))
                 || ((state == ST_ISSUE) && !m_stb_o && !req_live)
                 || ((state == ST_BACKOFF) && !req_live);

  rr_arbiter2 u_rr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (s_stb_i),
    .update_i     (ptr_upd),
    .update_idx_i (grant_q),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  // ISSUE is entered with m_stb_o low from IDLE (strobe rises one cycle later)
  // and with m_stb_o already high from BACKOFF, so the back-off is exact
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_GAP;
      cnt       <= '0;
      retry_cnt <= '0;
      grant_q   <= 1'b0;
      s_dat_o   <= '0;
      s_ack_o   <= '0;
      s_err_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_we_o    <= 1'b0;
      m_tga_o   <= 1'b0;
      m_stb_o   <= 1'b0;
    end else begin
      s_ack_o <= '0;
      s_err_o <= '0;
      case (state)
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q   <= arb_grant;
            m_adr_o   <= s_adr_i[arb_grant];
            m_dat_o   <= s_dat_i[arb_grant];
            m_we_o    <= (grant_op != OP_READ);
            m_tga_o   <= (grant_op == OP_ERASE);
            retry_cnt <= '0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!m_stb_o) begin
            if (!req_live) begin
              cnt   <= '0;
              state <= ST_GAP;
            end else begin
              m_stb_o <= 1'b1;
            end
          end else if (m_ack_i) begin
            s_dat_o <= m_dat_i;
            m_stb_o <= 1'b0;
            state   <= ST_DONE;
            if (req_live) s_ack_o[grant_q] <= 1'b1;
          end else if (m_rty_i) begin
            m_stb_o   <= 1'b0;
            retry_cnt <= retry_cnt + RETRY_W'(1);
            cnt       <= '0;
            if (!req_live) begin
              state <= ST_GAP;
            end else if (retry_last) begin
              s_err_o[grant_q] <= 1'b1;
              state            <= ST_DONE;
            end else begin
              state <= ST_BACKOFF;
            end
          end
        end
        ST_BACKOFF: begin
          if (!req_live) begin
            cnt   <= '0;
            state <= ST_GAP;
          end else if (cnt == BO_LAST) begin
            cnt     <= '0;
            m_stb_o <= 1'b1;
            state   <= ST_ISSUE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_GAP;
        end
        default: begin
          cnt   <= '0;
          state <= ST_GAP;
        end
      endcase
    end
  end

endmodule
